// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl: miss sequencer that writes back a dirty line word by word, then refills it from memory
module dcache_flush_ctrl #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32,
  parameter int CACHEADDRBITS = 5,
  parameter int BANKNUM = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] cpu_addr,
  input  logic                cpu_rdreq,
  input  logic                cpu_wrreq,
  output logic                cpu_stall,
  input  logic                line_miss,
  input  logic                line_dirty,
  input  logic [ADDRBITS-1:0] line_memory_section,
  input  logic [DATABITS-1:0] line_out,
  output logic                flush_mode,
  output logic                flush_we,
  output logic                flush_queue_rdreq,
  output logic                flush_queue_wrreq,
  output logic [ADDRBITS-1:0] flush_addr,
  output logic [DATABITS-1:0] flush_in,
  output logic [BANKNUM-1:0]  flush_byteenable,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  output logic [DATABITS-1:0] mem_out,
  input  logic [DATABITS-1:0] mem_in,
  input  logic                mem_ack
);
  localparam int L = CACHEADDRBITS + 2;
  typedef enum logic [2:0] {IDLE, WB_RD, WB_WR, FILL, DONE} state_t;
  state_t state, s;
  logic [CACHEADDRBITS-1:0] idx;
  logic [ADDRBITS-1:0] r_wb_base, r_fill_base, wb_addr, fill_addr;
  logic [DATABITS-1:0] r_wdata;
  logic first, miss, last;
  assign miss = (cpu_rdreq | cpu_wrreq) & line_miss;
  assign last = &idx;
  assign s = reset_n ? state : IDLE;
  assign wb_addr = {r_wb_base[ADDRBITS-1:L], r_wb_base[L-1:0] + {idx, 2'b00}};
  assign fill_addr = {r_fill_base[ADDRBITS-1:L], r_fill_base[L-1:0] + {idx, 2'b00}};
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      r_wb_base <= '0;
      r_fill_base <= '0;
      r_wdata <= '0;
      first <= 1'b0;
    end else
      case (state)
        IDLE: if (miss) begin
          r_fill_base <= cpu_addr & {{(ADDRBITS-L){1'b1}}, {L{1'b0}}};
          r_wb_base <= line_memory_section;
          idx <= '0;
          state <= line_dirty ? WB_RD : FILL;
        end
        WB_RD: begin
          first <= 1'b1;
          state <= WB_WR;
        end
        WB_WR: begin
          first <= 1'b0;
          if (first) r_wdata <= line_out;
          if (mem_ack) begin
            idx <= idx + 1'b1;
            state <= last ? FILL : WB_RD;
          end
        end
        FILL: if (mem_ack) begin
          idx <= idx + 1'b1;
          if (last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
  assign cpu_stall = (s != IDLE) | miss;
  assign flush_mode = s != IDLE;
  assign flush_queue_rdreq = s == WB_RD;
  assign mem_wrreq = s == WB_WR;
  assign mem_rdreq = s == FILL;
  assign flush_we = mem_rdreq & mem_ack;
  assign flush_queue_wrreq = flush_we;
  assign flush_byteenable = {BANKNUM{flush_we}};
  assign flush_in = flush_we ? mem_in : '0;
  assign mem_addr = mem_wrreq ? wb_addr : mem_rdreq ? fill_addr : '0;
  assign mem_out = mem_wrreq ? (first ? line_out : r_wdata) : '0;
  assign flush_addr = flush_queue_rdreq ? wb_addr : flush_we ? fill_addr : '0;
endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// tb_dcache_flush_ctrl: randomized self-checking bench against a transfer-level model of the miss sequence
module tb_dcache_flush_ctrl;
  localparam int N = 32;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [31:0] cpu_addr = '0, line_memory_section = '0, line_out = '0, mem_in = '0;
  logic cpu_rdreq = 1'b0, cpu_wrreq = 1'b0, line_miss = 1'b0, line_dirty = 1'b0, mem_ack = 1'b0;
  logic cpu_stall, flush_mode, flush_we, flush_queue_rdreq, flush_queue_wrreq, mem_rdreq, mem_wrreq;
  logic [31:0] flush_addr, flush_in, mem_addr, mem_out;
  logic [3:0] flush_byteenable;
  logic [31:0] line_data [N];
  int n_checks = 0, n_fail = 0;
  int done_c, end_c, exp_done;

  dcache_flush_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_rdreq(cpu_rdreq), .cpu_wrreq(cpu_wrreq),
    .cpu_stall(cpu_stall), .line_miss(line_miss), .line_dirty(line_dirty),
    .line_memory_section(line_memory_section), .line_out(line_out), .flush_mode(flush_mode),
    .flush_we(flush_we), .flush_queue_rdreq(flush_queue_rdreq), .flush_queue_wrreq(flush_queue_wrreq),
    .flush_addr(flush_addr), .flush_in(flush_in), .flush_byteenable(flush_byteenable),
    .mem_addr(mem_addr), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq), .mem_out(mem_out),
    .mem_in(mem_in), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic run_miss(input bit dirty, input logic [31:0] sect, input logic [31:0] addr,
                          input int mind, input int maxd, output int dc, output int ec, output int ed);
    logic [31:0] orig [N];
    logic [31:0] fb;
    logic [4:0] pidx;
    int nw, nr, waited, d;
    bit pend, fill_done;
    fb = {addr[31:7], 7'b0};
    for (int i = 0; i < N; i++) begin
      line_data[i] = $urandom;
      orig[i] = line_data[i];
    end
    ed = 1; nw = 0; nr = 0; waited = 0; pend = 0; fill_done = 0; dc = -1; ec = -1; pidx = '0;
    d = $urandom_range(maxd, mind);
    @(negedge clk);
    cpu_addr = addr;
    line_memory_section = sect;
    line_dirty = dirty;
    line_miss = 1'b1;
    cpu_rdreq = $urandom_range(1, 0);
    cpu_wrreq = !cpu_rdreq;
    mem_ack = $urandom_range(1, 0);
    #1;
    n_checks++;
    if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL miss_stall_c0: got %b want 1", cpu_stall); end
    for (int c = 1; c <= 3000 && ec < 0; c++) begin
      @(negedge clk);
      if (fill_done) line_miss = 1'b0;
      line_out = pend ? line_data[pidx] : $urandom;
      pend = 0;
      mem_in = $urandom;
      mem_ack = (mem_rdreq | mem_wrreq) ? (waited == d) : 1'($urandom_range(1, 0));
      #1;
      if (!cpu_stall) begin
        ec = c;
        n_checks++;
        if ({flush_mode, mem_rdreq, mem_wrreq, flush_we} !== 4'b0) begin
          n_fail++; $display("FAIL idle_quiet: got %b want 0000", {flush_mode, mem_rdreq, mem_wrreq, flush_we});
        end
      end else begin
        n_checks++;
        if (flush_mode !== 1'b1) begin n_fail++; $display("FAIL busy_flush_mode c%0d: got %b want 1", c, flush_mode); end
      end
      if (flush_queue_rdreq) begin
        n_checks++;
        if (flush_addr !== sect + 32'(4 * nw)) begin
          n_fail++; $display("FAIL wb_rd_addr w%0d: got %h want %h", nw, flush_addr, sect + 32'(4 * nw));
        end
        pend = 1;
        pidx = flush_addr[6:2];
      end
      if (mem_wrreq) begin
        n_checks++;
        if (mem_addr !== sect + 32'(4 * nw) || mem_out !== orig[nw] || mem_rdreq !== 1'b0) begin
          n_fail++;
          $display("FAIL wb_write w%0d: got addr %h data %h rd %b want addr %h data %h rd 0",
                   nw, mem_addr, mem_out, mem_rdreq, sect + 32'(4 * nw), orig[nw]);
        end
        if (mem_ack) begin
          nw++;
          ed += 2 + d;
        end
      end
      if (mem_rdreq) begin
        n_checks++;
        if (mem_addr !== fb + 32'(4 * nr) || nw !== (dirty ? N : 0)) begin
          n_fail++; $display("FAIL fill_addr r%0d: got %h after %0d writes want %h", nr, mem_addr, nw, fb + 32'(4 * nr));
        end
        n_checks++;
        if ({flush_we, flush_queue_wrreq, flush_byteenable} !== (mem_ack ? 6'h3f : 6'h0) ||
            (mem_ack && (flush_addr !== mem_addr || flush_in !== mem_in))) begin
          n_fail++;
          $display("FAIL fill_write r%0d: got we/wr/be %b addr %h data %h want ack %b addr %h data %h",
                   nr, {flush_we, flush_queue_wrreq, flush_byteenable}, flush_addr, flush_in, mem_ack, mem_addr, mem_in);
        end
        if (mem_ack) begin
          line_data[nr] = mem_in;
          nr++;
          ed += 1 + d;
          fill_done = nr == N;
        end
      end else begin
        n_checks++;
        if (flush_we !== 1'b0) begin n_fail++; $display("FAIL stray_flush_we c%0d: got 1 want 0", c); end
      end
      if ((mem_rdreq | mem_wrreq) && mem_ack) begin
        waited = 0;
        d = $urandom_range(maxd, mind);
      end else if (mem_rdreq | mem_wrreq) waited++;
      if (dc < 0 && flush_mode && !mem_rdreq && !mem_wrreq && !flush_queue_rdreq) dc = c;
    end
    n_checks++;
    if (ec < 0) begin n_fail++; $display("FAIL miss_timeout: stall still high, want release"); end
    n_checks++;
    if (nw !== (dirty ? N : 0) || nr !== N) begin
      n_fail++; $display("FAIL transfer_count: got %0d writes %0d reads want %0d writes %0d reads", nw, nr, dirty ? N : 0, N);
    end
    n_checks++;
    if (dc !== ed || ec !== ed + 1) begin
      n_fail++; $display("FAIL latency: got done %0d idle %0d want done %0d idle %0d", dc, ec, ed, ed + 1);
    end
    cpu_rdreq = 1'b0;
    cpu_wrreq = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_rdreq = $urandom_range(1, 0);
      cpu_wrreq = $urandom_range(1, 0);
      line_miss = i[0];
      line_dirty = $urandom_range(1, 0);
      mem_ack = $urandom_range(1, 0);
      mem_in = $urandom;
      line_out = $urandom;
      #1;
      n_checks++;
      if (cpu_stall !== ((cpu_rdreq | cpu_wrreq) & line_miss)) begin
        n_fail++; $display("FAIL reset_stall: got %b want %b", cpu_stall, (cpu_rdreq | cpu_wrreq) & line_miss);
      end
      n_checks++;
      if ({flush_mode, flush_we, flush_queue_rdreq, flush_queue_wrreq, mem_rdreq, mem_wrreq, flush_byteenable} !== 10'b0 ||
          {flush_addr, flush_in, mem_addr, mem_out} !== 128'b0) begin
        n_fail++; $display("FAIL reset_outputs: got ctl %b mem_addr %h want all zero",
                           {flush_mode, flush_we, flush_queue_rdreq, flush_queue_wrreq, mem_rdreq, mem_wrreq, flush_byteenable}, mem_addr);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    cpu_rdreq = 1'b0;
    cpu_wrreq = 1'b0;
    line_miss = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({cpu_stall, flush_mode, mem_rdreq, mem_wrreq, flush_queue_rdreq} !== 5'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b want 00000", {cpu_stall, flush_mode, mem_rdreq, mem_wrreq, flush_queue_rdreq});
    end
  endtask

  task automatic test_clean_miss;
    run_miss(1'b0, 32'h0009_8000, 32'h0000_1234, 0, 0, done_c, end_c, exp_done);
    n_checks++;
    if (end_c !== 34) begin n_fail++; $display("FAIL clean_release_cycle: got %0d want 34", end_c); end
  endtask

  task automatic test_dirty_miss;
    run_miss(1'b1, 32'h0000_4000, 32'h0000_8010, 0, 0, done_c, end_c, exp_done);
    n_checks++;
    if (done_c !== 97) begin n_fail++; $display("FAIL dirty_done_cycle: got %0d want 97", done_c); end
  endtask

  task automatic test_dirty_wait;
    run_miss(1'b1, 32'h0000_4000, 32'h0000_8010, 3, 3, done_c, end_c, exp_done);
    n_checks++;
    if (done_c !== 97 + 3 * 2 * N) begin n_fail++; $display("FAIL wait_done_cycle: got %0d want %0d", done_c, 97 + 3 * 2 * N); end
  endtask

  task automatic test_hit;
    @(negedge clk);
    line_miss = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_rdreq = 1'b1;
      cpu_wrreq = $urandom_range(1, 0);
      line_dirty = $urandom_range(1, 0);
      mem_ack = $urandom_range(1, 0);
      #1;
      n_checks++;
      if ({cpu_stall, flush_mode, flush_we, flush_queue_rdreq, flush_queue_wrreq, mem_rdreq, mem_wrreq} !== 7'b0) begin
        n_fail++; $display("FAIL hit_quiet: got %b want 0000000",
                           {cpu_stall, flush_mode, flush_we, flush_queue_rdreq, flush_queue_wrreq, mem_rdreq, mem_wrreq});
      end
    end
    cpu_rdreq = 1'b0;
    cpu_wrreq = 1'b0;
  endtask

  task automatic test_reset_mid_fill;
    @(negedge clk);
    cpu_addr = 32'h0001_2344;
    line_dirty = 1'b0;
    line_miss = 1'b1;
    cpu_rdreq = 1'b1;
    mem_ack = 1'b1;
    for (int c = 1; c <= 11; c++) @(negedge clk);
    #1;
    n_checks++;
    if (mem_rdreq !== 1'b1 || mem_addr !== 32'h0001_2300 + 32'd40) begin
      n_fail++; $display("FAIL pre_abort_fill: got rd %b addr %h want rd 1 addr %h", mem_rdreq, mem_addr, 32'h0001_2328);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    line_miss = 1'b0;
    cpu_rdreq = 1'b0;
    #1;
    n_checks++;
    if ({cpu_stall, flush_mode, mem_rdreq, mem_wrreq, flush_we} !== 5'b0 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL abort_idle: got %b addr %h want 00000 addr 0", {cpu_stall, flush_mode, mem_rdreq, mem_wrreq, flush_we}, mem_addr);
    end
    run_miss(1'b0, 32'h0000_0000, 32'h0001_2344, 0, 0, done_c, end_c, exp_done);
    n_checks++;
    if (end_c !== 34) begin n_fail++; $display("FAIL restart_release_cycle: got %0d want 34", end_c); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      run_miss(1'($urandom_range(1, 0)), {$urandom(), 7'b0} >> 7 << 7, $urandom, 0, 3, done_c, end_c, exp_done);
  endtask

  initial begin
    test_reset;
    test_clean_miss;
    test_dirty_miss;
    test_dirty_wait;
    test_hit;
    test_reset_mid_fill;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_flush_ctrl.md
# dcache_flush_ctrl

Miss/flush sequencer for one data-cache line. It sits between the CPU-side access lines, the line's flush port and a simple word-wide memory bus. On a miss it stalls the CPU, writes the resident line back word by word if the line is dirty, then refills all words from the missed memory section. The refilled line is marked clean.

## Interface
- DATABITS, 32, data word width
- ADDRBITS, 32, byte address width
- CACHEADDRBITS, 5, word-index bits; line holds 2^CACHEADDRBITS words
- BANKNUM, 4, byte lanes per word (DATABITS/8)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_addr  in  ADDRBITS  address of current CPU access
- cpu_rdreq, cpu_wrreq  in  1  CPU access request (either = access)
- cpu_stall  out  1  CPU must hold its request
- line_miss, line_dirty  in  1  status from cache line
- line_memory_section  in  ADDRBITS  base address of resident line (low CACHEADDRBITS+2 bits zero)
- line_out  in  DATABITS  line read data, valid 1 cycle after flush_queue_rdreq
- flush_mode, flush_we, flush_queue_rdreq, flush_queue_wrreq  out  1  line flush-port controls
- flush_addr  out  ADDRBITS  word address into line
- flush_in  out  DATABITS  refill data
- flush_byteenable  out  BANKNUM  refill byte enables
- mem_addr  out  ADDRBITS  memory word address
- mem_rdreq, mem_wrreq  out  1  memory requests, held until mem_ack
- mem_out  out  DATABITS  write-back data
- mem_in  in  DATABITS  read data, valid with mem_ack
- mem_ack  in  1  single-cycle acknowledge; may be asserted in the same cycle as the request

## Operation
- State registers: state, idx[CACHEADDRBITS-1:0], r_wb_base, r_fill_base, r_wdata.
- FSM states: IDLE, WB_RD, WB_WR, FILL, DONE.
- IDLE:
  - If (cpu_rdreq|cpu_wrreq) & line_miss:
    - latch r_fill_base = cpu_addr with low CACHEADDRBITS+2 bits cleared
    - latch r_wb_base = line_memory_section; set idx=0
    - go to WB_RD if line_dirty, else FILL.
  - Otherwise stay in IDLE.
- WB_RD: flush_mode=1, flush_queue_rdreq=1, flush_addr=r_wb_base+{idx,2'b00}. Next state is always WB_WR.
- WB_WR:
  - First cycle: capture line_out into r_wdata.
  - Drive mem_wrreq=1, mem_addr=r_wb_base+{idx,2'b00}, mem_out=line_out on the first cycle, then r_wdata; hold all of them until mem_ack.
  - On ack: if idx is the last word, clear idx and go to FILL; else increment idx and go to WB_RD.
- FILL:
  - Drive mem_rdreq=1, mem_addr=r_fill_base+{idx,2'b00} until mem_ack.
  - In the ack cycle: flush_we=1, flush_queue_wrreq=1 (line becomes clean), flush_in=mem_in, flush_byteenable=all ones, flush_addr=mem_addr.
  - On the last word go to DONE, else increment idx.
- DONE: flush_mode=1 for one cycle, then IDLE.
- flush_mode=1 in every state except IDLE.
- cpu_stall = (state!=IDLE) | ((cpu_rdreq|cpu_wrreq) & line_miss).
- CPU requests are ignored while busy; they are re-evaluated in IDLE.
- mem_ack arriving with no request outstanding is ignored.
- idx wraps modulo 2^CACHEADDRBITS. The wrap condition is idx all-ones at ack.
- Address arithmetic is ADDRBITS wide, with no carry into r_*_base above bit CACHEADDRBITS+1.

## Timing
- Reset (sync, reset_n=0 at a clock edge):
  - state=IDLE, idx=0, r_* =0
  - all outputs 0 except cpu_stall, which is combinational and follows the miss input.
- Reset mid-operation aborts immediately with no further memory or line writes. The partial line contents are undefined.
- Miss detected in cycle 0; the first WB_RD or FILL state is in cycle 1.
- Clean miss with mem_ack tied high: FILL in cycles 1..N (N=2^CACHEADDRBITS), DONE in cycle N+1, IDLE in cycle N+2.
- Dirty miss with mem_ack tied high: 2 cycles per word of write-back, so FILL starts in cycle 2N+1 and DONE is in cycle 3N+1.
- Each mem_ack wait cycle adds exactly one cycle. Request, address and data stay stable across waits.

## Test plan
- Post-reset first access (line_miss=1, line_dirty=0, cpu_addr=0x0000_1234, mem_ack=1) -> 32 mem reads at 0x1200..0x127C; flush_we on each with flush_queue_wrreq=1; cpu_stall low in cycle 34.
- Dirty miss (line_memory_section=0x0000_4000, cpu_addr=0x0000_8010) -> 32 writes 0x4000..0x407C carrying line_out data, then 32 reads 0x8000..0x807C; DONE in cycle 97.
- mem_ack delayed 3 cycles per word on the dirty miss -> mem_addr, mem_out and mem_wrreq stable during waits; total latency grows by 3 per transfer.
- Hit (line_miss=0, cpu_rdreq=1) -> cpu_stall=0; no flush or memory activity.
- reset_n low in FILL at idx=10 -> next cycle state IDLE, mem_rdreq=0, flush_mode=0; a new miss restarts at idx 0.
- Spurious mem_ack in IDLE, and an ack asserted in the same cycle as a request -> ignored and accepted respectively; no extra idx increment.
